rtc_bus_transfer: RTL and testbench
===================================

# rtc_bus_transfer

Bus-cycle engine for the RTC's multiplexed address/data port. It sits directly downstream of the RTC command selector and consumes its 8-bit command byte (0xF0 clock/timer transfer, 0xF1 date/clock transfer, 0x08 timer transfer) together with plain register reads and writes from the controller FSM. Each request becomes one complete two-phase bus transaction: an address phase, then a data phase, with programmable strobe and gap widths. Reads return the sampled byte on a held output register.

## Interface
- T_STROBE, 4: width of each RD#/WR# low pulse, in clk cycles; legal range 1..255.
- T_GAP, 2: all-strobes-high cycles after each strobe; legal range 1..255.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  2  request type, latched with start: 00 write, 01 read, 10 command, 11 treated as read.
- cmd_in  input  8  command byte from the command selector; used when mode=10.
- addr_in  input  8  register address; used when mode=00/01.
- data_wr  input  8  write data; used when mode=00.
- ad_in  input  8  AD bus value from the pad.
- ad_out  output  8  AD bus drive value.
- ad_oe  output  1  1 = FPGA drives the AD bus.
- a_d  output  1  0 = address phase, 1 = data phase.
- cs_n  output  1  RTC chip select, active low.
- rd_n  output  1  read strobe, active low.
- wr_n  output  1  write strobe, active low.
- data_rd  output  8  last byte read; held until the next read completes.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse at transaction end.

## Operation
- All outputs are registered.
- Reset values: cs_n=1, rd_n=1, wr_n=1, a_d=0, ad_oe=0, ad_out=0x00, data_rd=0x00, busy=0, done=0. State goes to IDLE and counters clear.
- States and their output values:
  - IDLE: all strobes and cs_n high, ad_oe=0, busy=0.
  - A_SETUP (1 cycle): cs_n=0, a_d=0, ad_oe=1. ad_out = cmd_in if mode=10, otherwise addr_in. The byte is latched at start and inputs are ignored afterwards.
  - A_STROBE (T_STROBE cycles): wr_n=0; address held.
  - A_GAP (T_GAP cycles): wr_n=1; address still driven.
  - D_SETUP (1 cycle): a_d=1.
    - Write: ad_out = latched data_wr, ad_oe=1.
    - Command: ad_out=0x00, ad_oe=1. The command byte is always followed by a dummy data write of 0x00.
    - Read: ad_oe=0.
  - D_STROBE (T_STROBE cycles): wr_n=0 for write/command, rd_n=0 for read.
  - D_GAP (T_GAP cycles): strobes high, cs_n still 0, data/ad_oe unchanged.
  - DONE (1 cycle): cs_n=1, ad_oe=0, a_d=0, done=1.
  - DONE always returns to IDLE.
- Phase rules:
  - rd_n and wr_n are never low in the same cycle.
  - Neither strobe is low in any SETUP or GAP cycle.
- Read capture: data_rd loads ad_in on the rising edge that ends the last D_STROBE cycle. This happens only for read requests.
- start while busy=1 (including the DONE cycle) is ignored; there is no queuing.
- Reset asserted mid-transaction: outputs go to their reset values immediately (asynchronous). The transaction is abandoned and data_rd is cleared.

## Timing
- Cycle 0 is the edge that samples start=1 in IDLE.
- Occupancy with defaults (T_STROBE=4, T_GAP=2):
  - A_SETUP cycle 1, A_STROBE 2–5, A_GAP 6–7.
  - D_SETUP 8, D_STROBE 9–12, D_GAP 13–14, DONE 15.
- General formula: done occurs in cycle 3+2·T_STROBE+2·T_GAP.
- busy is high from cycle 1 through DONE inclusive.
- The next start is accepted at the earliest in cycle done+1.
- Read data is valid on data_rd from cycle 1+T_STROBE+T_GAP+1+T_STROBE+1 (cycle 13 with defaults) onward, so it is valid when done=1.
- Strobe counters are 8-bit down-counters loaded with T−1 on state entry; the state exits when the count reaches 0.

## Test plan
- Write, defaults: mode=00, addr_in=0x21, data_wr=0x37, start in cycle 0.
  - Cycles 2–5: wr_n=0, a_d=0, ad_out=0x21.
  - Cycles 9–12: wr_n=0, a_d=1, ad_out=0x37.
  - rd_n stays 1 throughout; done=1 only in cycle 15.
- Read: mode=01, addr_in=0x22, ad_in=0x59 during cycles 9–12.
  - Cycles 8–14: ad_oe=0. Cycles 9–12: rd_n=0.
  - data_rd=0x59 from cycle 13 and still 0x59 after return to IDLE.
- Command: mode=10, cmd_in=0xF0.
  - Address phase drives 0xF0; data phase drives 0x00 with wr_n low.
  - Repeat with 0xF1 and 0x08 and require the same waveform shape.
- Busy rejection: pulse start in cycles 5 and 15.
  - Neither pulse starts a new transaction; busy falls in cycle 16.
  - start in cycle 16 begins a transaction with A_SETUP in cycle 17.
- Reset mid-strobe: assert reset during cycle 10 of a read.
  - cs_n, rd_n, wr_n go to 1, and ad_oe and data_rd go to 0, within the same cycle.
  - After release, state is IDLE and the next start behaves normally.
- Parameter sweep: T_STROBE=1, T_GAP=1 gives done in cycle 7. T_STROBE=255 gives strobe pulses exactly 255 cycles wide.

Source files
------------

// File: rtl/rtc_bus_transfer.sv
// Two-phase bus-cycle engine for the RTC multiplexed AD port: address phase then data phase,
// with T_STROBE-wide strobes and T_GAP idle cycles after each strobe.
module rtc_bus_transfer #(
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_GAP    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] cmd_in,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done
);

    // state     | meaning
    // IDLE      | waiting for start
    // A_SETUP   | address driven, strobes high
    // A_STROBE  | address latched into RTC with wr_n low
    // A_GAP     | strobes high, address still driven
    // D_SETUP   | data phase set up (a_d=1)
    // D_STROBE  | rd_n or wr_n low
    // D_GAP     | strobes high, cs_n still low
    // DONE      | chip deselected, done pulse
    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_GAP, D_SETUP, D_STROBE, D_GAP, DONE
    } state_t;

    localparam logic [7:0] STB_LOAD = 8'(T_STROBE - 1);
    localparam logic [7:0] GAP_LOAD = 8'(T_GAP - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       is_read;
    logic [7:0] a_byte, d_byte;

    logic       cs_n_nxt, rd_n_nxt, wr_n_nxt, a_d_nxt, ad_oe_nxt, busy_nxt, done_nxt;
    logic [7:0] ad_out_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:     if (start) state_nxt = A_SETUP;
            A_SETUP:  begin state_nxt = A_STROBE; cnt_nxt = STB_LOAD; end
            A_STROBE: if (cnt == 8'd0) begin state_nxt = A_GAP; cnt_nxt = GAP_LOAD; end
                      else cnt_nxt = cnt - 8'd1;
            A_GAP:    if (cnt == 8'd0) state_nxt = D_SETUP;
                      else cnt_nxt = cnt - 8'd1;
            D_SETUP:  begin state_nxt = D_STROBE; cnt_nxt = STB_LOAD; end
            D_STROBE: if (cnt == 8'd0) begin state_nxt = D_GAP; cnt_nxt = GAP_LOAD; end
                      else cnt_nxt = cnt - 8'd1;
            D_GAP:    if (cnt == 8'd0) state_nxt = DONE;
                      else cnt_nxt = cnt - 8'd1;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so the pins lag the state by one cycle.
    always_comb begin
        cs_n_nxt   = 1'b1;
        rd_n_nxt   = 1'b1;
        wr_n_nxt   = 1'b1;
        a_d_nxt    = 1'b0;
        ad_oe_nxt  = 1'b0;
        ad_out_nxt = ad_out;
        busy_nxt   = 1'b1;
        done_nxt   = 1'b0;
        case (state)
            IDLE: busy_nxt = 1'b0;
            A_SETUP, A_STROBE, A_GAP: begin
                cs_n_nxt   = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = a_byte;
                wr_n_nxt   = (state != A_STROBE);
            end
            D_SETUP, D_STROBE, D_GAP: begin
                cs_n_nxt  = 1'b0;
                a_d_nxt   = 1'b1;
                ad_oe_nxt = !is_read;
                if (!is_read) ad_out_nxt = d_byte;
                if (state == D_STROBE) begin
                    rd_n_nxt = !is_read;
                    wr_n_nxt = is_read;
                end
            end
            DONE: done_nxt = 1'b1;
            default: busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            is_read <= 1'b0;
            a_byte  <= 8'h00;
            d_byte  <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && start) begin
                is_read <= mode[0];
                a_byte  <= (mode == 2'b10) ? cmd_in : addr_in;
                d_byte  <= (mode == 2'b10) ? 8'h00 : data_wr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b0;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            data_rd <= 8'h00;
        end else begin
            cs_n   <= cs_n_nxt;
            rd_n   <= rd_n_nxt;
            wr_n   <= wr_n_nxt;
            a_d    <= a_d_nxt;
            ad_oe  <= ad_oe_nxt;
            ad_out <= ad_out_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            // Sample on the edge that ends the last visible rd_n-low cycle.
            if (!rd_n && rd_n_nxt) data_rd <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_transfer.sv
// Directed bench for rtc_bus_transfer: table of transactions checked cycle by cycle against a
// phase-timing model, plus busy-rejection and mid-transaction reset sequences.
module tb_rtc_bus_transfer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] sel;
    logic [1:0] mode;
    logic [7:0] cmd_in, addr_in, data_wr, ad_in;

    logic [7:0] ad_out0, ad_out1, ad_out2, data_rd0, data_rd1, data_rd2;
    logic       ad_oe0, a_d0, cs_n0, rd_n0, wr_n0, busy0, done0;
    logic       ad_oe1, a_d1, cs_n1, rd_n1, wr_n1, busy1, done1;
    logic       ad_oe2, a_d2, cs_n2, rd_n2, wr_n2, busy2, done2;
    logic       start0, start1, start2;
    logic [22:0] obs;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_rd [3];

    always #5 clk = ~clk;

    assign start0 = start && (sel == 2'd0);
    assign start1 = start && (sel == 2'd1);
    assign start2 = start && (sel == 2'd2);

    rtc_bus_transfer #(.T_STROBE(4), .T_GAP(2)) dut (
        .clk(clk), .reset(reset), .start(start0), .mode(mode), .cmd_in(cmd_in),
        .addr_in(addr_in), .data_wr(data_wr), .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0),
        .a_d(a_d0), .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .data_rd(data_rd0),
        .busy(busy0), .done(done0));

    rtc_bus_transfer #(.T_STROBE(1), .T_GAP(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .cmd_in(cmd_in),
        .addr_in(addr_in), .data_wr(data_wr), .ad_in(ad_in), .ad_out(ad_out1), .ad_oe(ad_oe1),
        .a_d(a_d1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .data_rd(data_rd1),
        .busy(busy1), .done(done1));

    rtc_bus_transfer #(.T_STROBE(255), .T_GAP(2)) dut_wide (
        .clk(clk), .reset(reset), .start(start2), .mode(mode), .cmd_in(cmd_in),
        .addr_in(addr_in), .data_wr(data_wr), .ad_in(ad_in), .ad_out(ad_out2), .ad_oe(ad_oe2),
        .a_d(a_d2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .data_rd(data_rd2),
        .busy(busy2), .done(done2));

    // {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, ad_out, data_rd}
    always_comb begin
        case (sel)
            2'd1:    obs = {cs_n1, rd_n1, wr_n1, a_d1, ad_oe1, busy1, done1, ad_out1, data_rd1};
            2'd2:    obs = {cs_n2, rd_n2, wr_n2, a_d2, ad_oe2, busy2, done2, ad_out2, data_rd2};
            default: obs = {cs_n0, rd_n0, wr_n0, a_d0, ad_oe0, busy0, done0, ad_out0, data_rd0};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pins in cycle c after the start edge (cycle 0), from the phase occupancy table.
    function automatic logic [22:0] exp_vec(input int c, input int ts, input int tg, input logic rd,
                                            input logic [7:0] ab, input logic [7:0] db,
                                            input logic [7:0] rdd);
        logic cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a_d = 1'b0, oe = 1'b0, bsy = 1'b0, dn = 1'b0;
        logic [7:0] ao = 8'h00;
        int dsu = 2 + ts + tg;
        int last = 3 + 2 * ts + 2 * tg;
        if (c >= 1 && c <= last) bsy = 1'b1;
        if (c >= 1 && c < dsu) begin
            cs_n = 1'b0; oe = 1'b1; ao = ab;
            if (c >= 2 && c <= 1 + ts) wr_n = 1'b0;
        end else if (c >= dsu && c < last) begin
            cs_n = 1'b0; a_d = 1'b1; oe = !rd; ao = db;
            if (c > dsu && c <= dsu + ts) begin
                if (rd) rd_n = 1'b0;
                else    wr_n = 1'b0;
            end
        end else if (c == last) begin
            dn = 1'b1;
        end
        return {cs_n, rd_n, wr_n, a_d, oe, bsy, dn, ao, rdd};
    endfunction

    // ad_out is only meaningful while it is driven.
    function automatic logic [22:0] care(input logic [22:0] e);
        return e[18] ? 23'h7FFFFF : 23'h7F00FF;
    endfunction

    task automatic check(input string name, input int c, input logic [22:0] got,
                         input logic [22:0] exp, input logic [22:0] msk);
        checks++;
        if (((got ^ exp) & msk) != 23'h0) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h (cs rd wr ad oe busy done | ad_out | data_rd)",
                     name, c, got & msk, exp & msk);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] inst;
        int         ts;
        int         tg;
        logic [1:0] m;
        logic [7:0] a;
        logic [7:0] cm;
        logic [7:0] d;
        logic [7:0] rv;
        int         done_cyc;
    } vec_t;

    task automatic run_txn(input vec_t v);
        logic       rd = v.m[0];
        logic [7:0] ab = (v.m == 2'b10) ? v.cm : v.a;
        logic [7:0] db = (v.m == 2'b10) ? 8'h00 : v.d;
        int dend = 2 + 2 * v.ts + v.tg;
        int last = 3 + 2 * v.ts + 2 * v.tg;
        int seen = -1;
        logic [22:0] e;
        sel = v.inst; mode = v.m; addr_in = v.a; cmd_in = v.cm; data_wr = v.d; ad_in = 8'hEE;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble request inputs: the engine must use its latched copy.
        mode = ~v.m; addr_in = ~v.a; cmd_in = ~v.cm; data_wr = ~v.d;
        for (int c = 0; c <= last + 1; c++) begin
            if (rd && c > dend) exp_rd[v.inst] = v.rv;
            e = exp_vec(c, v.ts, v.tg, rd, ab, db, exp_rd[v.inst]);
            check(v.name, c, obs, e, care(e));
            if (obs[16] && seen < 0) seen = c;
            ad_in = (c > dend - v.ts && c <= dend) ? v.rv : 8'hEE;
            tick();
        end
        check_int({v.name, " done_cycle"}, seen, v.done_cyc);
    endtask

    vec_t vecs [10];
    logic [22:0] e;
    logic [22:0] rst_vec;
    bit got_done;

    initial begin
        vecs[0] = '{"write",      2'd0, 4,   2, 2'b00, 8'h21, 8'h00, 8'h37, 8'h00, 15};
        vecs[1] = '{"read",       2'd0, 4,   2, 2'b01, 8'h22, 8'h00, 8'h00, 8'h59, 15};
        vecs[2] = '{"cmd_f0",     2'd0, 4,   2, 2'b10, 8'h55, 8'hF0, 8'hAA, 8'h00, 15};
        vecs[3] = '{"cmd_f1",     2'd0, 4,   2, 2'b10, 8'h55, 8'hF1, 8'hAA, 8'h00, 15};
        vecs[4] = '{"cmd_08",     2'd0, 4,   2, 2'b10, 8'h55, 8'h08, 8'hAA, 8'h00, 15};
        vecs[5] = '{"mode11_read",2'd0, 4,   2, 2'b11, 8'h30, 8'h00, 8'h00, 8'hA5, 15};
        vecs[6] = '{"fast_write", 2'd1, 1,   1, 2'b00, 8'h10, 8'h00, 8'hC3, 8'h00, 7};
        vecs[7] = '{"fast_read",  2'd1, 1,   1, 2'b01, 8'h11, 8'h00, 8'h00, 8'h6E, 7};
        vecs[8] = '{"wide_write", 2'd2, 255, 2, 2'b00, 8'h40, 8'h00, 8'h99, 8'h00, 517};
        vecs[9] = '{"read_after_reset", 2'd0, 4, 2, 2'b01, 8'h23, 8'h00, 8'h00, 8'h3C, 15};

        rst_vec = 23'h700000;
        reset = 1'b1; start = 1'b0; sel = 2'd0; mode = 2'b00;
        cmd_in = 8'h00; addr_in = 8'h00; data_wr = 8'h00; ad_in = 8'h00;
        for (int i = 0; i < 3; i++) exp_rd[i] = 8'h00;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1 check("reset_state", 0, obs, rst_vec, 23'h7FFFFF);
        end
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Busy rejection: pulses sampled at edges 5 and 15 are ignored; one at edge 16 is accepted.
        sel = 2'd0; mode = 2'b00; addr_in = 8'h61; data_wr = 8'h62; cmd_in = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            e = exp_vec(c, 4, 2, 1'b0, 8'h61, 8'h62, exp_rd[0]);
            check("busy_reject", c, obs, e, care(e));
            start = (c == 4 || c == 14 || c == 15);
            tick();
        end
        start = 1'b0;
        e = exp_vec(1, 4, 2, 1'b0, 8'h61, 8'h62, exp_rd[0]);
        check("restart_a_setup", 17, obs, e, care(e));
        got_done = 1'b0;
        for (int c = 17; c < 60 && !got_done; c++) begin
            if (obs[16]) got_done = 1'b1;
            else tick();
        end
        check_int("restart_done_seen", int'(got_done), 1);
        tick();

        // Mid-strobe reset during a read, after a previous read left data in data_rd.
        run_txn(vecs[1]);
        sel = 2'd0; mode = 2'b01; addr_in = 8'h24; ad_in = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        e = exp_vec(10, 4, 2, 1'b1, 8'h24, 8'h00, exp_rd[0]);
        check("pre_reset_strobe", 10, obs, e, care(e));
        reset = 1'b1;
        #1;
        exp_rd[0] = 8'h00;
        check("async_reset", 10, obs, rst_vec, 23'h7FFFFF);
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_reset", 0, obs, rst_vec, 23'h7FFFFF);
        run_txn(vecs[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
